// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with per-lane valid/squash, stall-vector
// bubble/hold/advance handling, flush, delay-slot tracking and perf counters.
module pipe_stage_reg #(
  parameter int LANES       = 1,
  parameter int LANE_W      = 32,
  parameter int STALL_W     = 6,
  parameter int STAGE       = 2,
  parameter int ZERO_BUBBLE = 1,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      flush,
  input  logic [LANES-1:0]          in_valid,
  input  logic [LANES*LANE_W-1:0]   in_data,
  input  logic [LANES-1:0]          kill_mask,
  input  logic                      in_ds_next,
  input  logic                      cnt_clr,
  output logic [LANES-1:0]          out_valid,
  output logic [LANES*LANE_W-1:0]   out_data,
  output logic                      out_ds,
  output logic                      flush_o,
  output logic                      any_valid,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          bubble_cnt
);

  typedef enum logic [1:0] {ACT_FLUSH, ACT_BUBBLE, ACT_HOLD, ACT_ADV} act_t;

  act_t                    act;
  logic [LANES-1:0]        cap_vld;
  logic [LANES*LANE_W-1:0] cap_data;

  logic [LANES-1:0]        vld_p1;
  logic [LANES*LANE_W-1:0] data_p1;
  logic                    ds_p1;
  logic                    flush_p1;
  logic [CNT_W-1:0]        stall_cnt_p1;
  logic [CNT_W-1:0]        bubble_cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // A stopped stage feeding a running one emits a bubble; both stopped means hold.
  always_comb begin
    if (flush)
      act = ACT_FLUSH;
    else if (stall[STAGE] && !stall[STAGE+1])
      act = ACT_BUBBLE;
    else if (stall[STAGE])
      act = ACT_HOLD;
    else
      act = ACT_ADV;
  end

  always_comb begin
    cap_vld  = in_valid & ~kill_mask;
    cap_data = in_data;
    for (int i = 0; i < LANES; i++) begin
      if ((ZERO_BUBBLE != 0) && !cap_vld[i])
        cap_data[i*LANE_W +: LANE_W] = '0;
    end
  end

  // Stage boundary: upstream -> registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= '0;
      data_p1  <= '0;
      ds_p1    <= 1'b0;
      flush_p1 <= 1'b0;
    end else begin
      flush_p1 <= flush;
      case (act)
        ACT_FLUSH: begin
          vld_p1 <= '0;
          ds_p1  <= 1'b0;
          if (ZERO_BUBBLE != 0) data_p1 <= '0;
        end
        ACT_BUBBLE: begin
          vld_p1 <= '0;
          if (ZERO_BUBBLE != 0) data_p1 <= '0;
        end
        ACT_HOLD: ;
        default: begin
          vld_p1  <= cap_vld;
          data_p1 <= cap_data;
          ds_p1   <= in_ds_next;
        end
      endcase
    end
  end

  // Clear beats increment; a flush cycle counts as neither stall nor bubble.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt_p1  <= '0;
      bubble_cnt_p1 <= '0;
    end else begin
      if (act == ACT_HOLD)   stall_cnt_p1  <= sat_inc(stall_cnt_p1);
      if (act == ACT_BUBBLE) bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = data_p1;
  assign out_ds     = ds_p1;
  assign flush_o    = flush_p1;
  assign any_valid  = |vld_p1;
  assign stall_cnt  = stall_cnt_p1;
  assign bubble_cnt = bubble_cnt_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: two lanes, 4-bit counters, STAGE = 2.
module tb_pipe_stage_reg;
  localparam int LANES = 2, LANE_W = 32, STALL_W = 6, CNT_W = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [STALL_W-1:0]      stall;
  logic                    flush;
  logic [LANES-1:0]        in_valid;
  logic [LANES*LANE_W-1:0] in_data;
  logic [LANES-1:0]        kill_mask;
  logic                    in_ds_next;
  logic                    cnt_clr;
  logic [LANES-1:0]        out_valid;
  logic [LANES*LANE_W-1:0] out_data;
  logic                    out_ds;
  logic                    flush_o;
  logic                    any_valid;
  logic [CNT_W-1:0]        stall_cnt;
  logic [CNT_W-1:0]        bubble_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(
    .LANES(LANES), .LANE_W(LANE_W), .STALL_W(STALL_W), .STAGE(2),
    .ZERO_BUBBLE(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .kill_mask(kill_mask),
    .in_ds_next(in_ds_next), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_data(out_data), .out_ds(out_ds),
    .flush_o(flush_o), .any_valid(any_valid),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 2'b11;
    in_data = {32'h5555_5555, 32'h6666_6666}; kill_mask = '0;
    in_ds_next = 1'b1; cnt_clr = 1'b0;
    step(2);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_ds", 64'(out_ds), 64'h0);
    chk("rst_flush_o", 64'(flush_o), 64'h0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    chk("rst_bubble_cnt", 64'(bubble_cnt), 64'h0);

    // Advance with lane 1 squashed
    rst = 1'b0; in_valid = 2'b11; kill_mask = 2'b10;
    in_data = {32'hBBBB_BBBB, 32'hAAAA_AAAA}; in_ds_next = 1'b1;
    step(1);
    chk("adv_valid", 64'(out_valid), 64'h1);
    chk("adv_lane0", 64'(out_data[31:0]), 64'hAAAA_AAAA);
    chk("adv_lane1", 64'(out_data[63:32]), 64'h0);
    chk("adv_ds", 64'(out_ds), 64'h1);
    chk("adv_any", 64'(any_valid), 64'h1);

    // Bubble for 3 cycles
    kill_mask = '0; in_ds_next = 1'b0; stall = 6'b000100;
    step(3);
    chk("bub_valid", 64'(out_valid), 64'h0);
    chk("bub_data", out_data, 64'h0);
    chk("bub_ds", 64'(out_ds), 64'h1);
    chk("bub_bubble_cnt", 64'(bubble_cnt), 64'h3);
    chk("bub_stall_cnt", 64'(stall_cnt), 64'h0);
    chk("bub_any", 64'(any_valid), 64'h0);

    // Load lane 0 then hold 4 cycles with changing input
    stall = '0; in_valid = 2'b01; in_data = {32'hDEAD_BEEF, 32'h1234_5678};
    in_ds_next = 1'b1;
    step(1);
    stall = 6'b001100;
    for (int k = 0; k < 4; k++) begin
      in_data = {32'h0F0F_0000 + 32'(k), 32'h9999_0000 + 32'(k)};
      in_valid = 2'b10; in_ds_next = 1'b0;
      step(1);
    end
    chk("hold_valid", 64'(out_valid), 64'h1);
    chk("hold_lane0", 64'(out_data[31:0]), 64'h1234_5678);
    chk("hold_ds", 64'(out_ds), 64'h1);
    chk("hold_stall_cnt", 64'(stall_cnt), 64'h4);
    chk("hold_bubble_cnt", 64'(bubble_cnt), 64'h3);

    // Flush together with hold
    flush = 1'b1;
    step(1);
    chk("fl_valid", 64'(out_valid), 64'h0);
    chk("fl_ds", 64'(out_ds), 64'h0);
    chk("fl_data", out_data, 64'h0);
    chk("fl_stall_cnt", 64'(stall_cnt), 64'h4);
    chk("fl_bubble_cnt", 64'(bubble_cnt), 64'h3);
    chk("fl_flush_o", 64'(flush_o), 64'h1);
    flush = 1'b0;
    step(1);
    chk("fl_flush_o_drop", 64'(flush_o), 64'h0);
    chk("fl_hold_cnt", 64'(stall_cnt), 64'h5);

    // stall[STAGE]=0 with stall[STAGE+1]=1 still advances
    stall = 6'b001000; in_valid = 2'b10; kill_mask = 2'b00;
    in_data = {32'hCAFE_F00D, 32'h7777_7777}; in_ds_next = 1'b1;
    step(1);
    chk("adv2_valid", 64'(out_valid), 64'h2);
    chk("adv2_data", out_data, {32'hCAFE_F00D, 32'h0});
    chk("adv2_ds", 64'(out_ds), 64'h1);

    // Saturation: 20 more hold cycles from 5
    stall = 6'b001100; kill_mask = 2'b11;
    step(20);
    chk("sat_stall_cnt", 64'(stall_cnt), 64'hF);
    chk("sat_valid", 64'(out_valid), 64'h2);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    chk("clr_stall_cnt", 64'(stall_cnt), 64'h0);
    chk("clr_bubble_cnt", 64'(bubble_cnt), 64'h0);

    // Mid-operation reset with stall and flush asserted
    step(1);
    chk("pre_rst_cnt", 64'(stall_cnt), 64'h1);
    rst = 1'b1; flush = 1'b1;
    step(1);
    chk("mrst_valid", 64'(out_valid), 64'h0);
    chk("mrst_data", out_data, 64'h0);
    chk("mrst_flush_o", 64'(flush_o), 64'h0);
    chk("mrst_stall_cnt", 64'(stall_cnt), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
